lcd_nibble_rx: RTL and testbench
================================

# lcd_nibble_rx

Responder for the 4-bit character-LCD write bus (sf_e, e, rs, rw, data nibble d/c/b/a) that the display driver logic in this codebase produces. Samples the bus in the 50 MHz system clock domain, runs the power-on 8-bit-to-4-bit mode sequence, assembles nibbles into bytes, decodes the instruction set and holds a 32-character DDRAM image plus display/entry state. It serves as the on-chip loopback checker and simulation model that the driver's output is verified against.

## Interface
- No parameters.
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- sf_e  in  1  1 = LCD access selected; strobes are ignored while 0
- lcd_e  in  1  enable strobe, asynchronous to clk
- lcd_rs  in  1  register select: 0 = instruction, 1 = data
- lcd_rw  in  1  1 = read, 0 = write
- lcd_nib  in  4  {d,c,b,a}, bit 3 = d
- byte_valid  out  1  one-cycle pulse, a full byte was assembled
- byte_data  out  8  last assembled byte
- byte_rs  out  1  rs of last assembled byte
- busy  out  1  clear-display sweep in progress
- ac  out  7  DDRAM address counter
- disp_on, cursor_on, blink_on  out  1 each  display-control bits
- entry_inc, entry_shift  out  1 each  entry-mode bits
- err  out  1  sticky: strobe dropped while busy
- rd_idx  in  5  character index, 0-15 = line 0, 16-31 = line 1
- rd_char  out  8  registered DDRAM contents at rd_idx (1-cycle latency)
- rd_nib  out  4  read-back nibble (LCD_RX_READ_EN only)
- rd_oe  out  1  read-back drive enable (LCD_RX_READ_EN only)

## Operation
- Inputs pass a 2-flop synchronizer; a strobe is a falling edge of synchronized lcd_e with sf_e=1; rs, rw, nib are taken from the same synchronized sample.
- Mode FSM: INIT8 -> (write nibble 0x2, rs=0) -> HI -> LO -> HI ... In INIT8 every write nibble is treated as the upper half of an 8-bit instruction with lower half 0; nibble 0x3 is accepted with no effect; other values set err and are ignored.
- HI stores the nibble as byte[7:4]; LO completes byte[3:0], pulses byte_valid and decodes. rs captured in LO is used.
- Instruction decode (rs=0), highest set bit wins: 0x01 clear; 0x02/0x03 home (ac=0); 0x04-0x07 entry mode (I/D=bit1, S=bit0); 0x08-0x0F display control (D,C,B = bits 2,1,0); 0x10-0x3F accepted, no state effect; 0x80+ set ac = byte[6:0].
- Data write (rs=1): if ac in 0x00-0x0F store at idx ac; if 0x40-0x4F at idx 16+(ac-0x40); otherwise not stored. ac then steps by entry_inc.
- ac step: inc 0x27->0x40, 0x67->0x00; dec 0x00->0x67, 0x40->0x27; other values +/-1.
- Clear: busy=1 for 32 cycles writing 0x20 to idx 0..31, ac=0, entry_inc=1. Any strobe while busy is dropped (no nibble-phase advance) and sets err.
- Strobes with rw=1 never alter state or nibble phase.

## Timing
- Reset: mode INIT8, all outputs 0 except entry_inc=1; DDRAM contents after reset are undefined until first clear.
- lcd_e high and low each must be held >= 3 clk cycles; shorter pulses may be missed.
- Strobe recognized 3 cycles after lcd_e falls at the pin; byte_valid, state updates and DDRAM write occur in the next cycle.
- busy rises the cycle after the clear byte_valid and falls exactly 32 cycles later.
- rst_n mid-operation: immediate return to reset state; partially assembled nibble discarded.

## Configuration
- LCD_RX_READ_EN defined: on a strobe rising edge with rw=1, rs=0, drive rd_oe=1 and rd_nib = {busy, ac[6:4]} in HI phase, ac[3:0] in LO phase; the phase advances on the falling edge; rd_oe drops on that falling edge. rw=1, rs=1 reads return the DDRAM byte at ac halves and step ac after the LO nibble.
- Not defined: rd_nib and rd_oe held at 0; read strobes ignored.

## Test plan
- Reset, nibbles 3,3,3,2 rs=0 -> mode HI, err=0, no byte_valid.
- After init, 0x28, 0x06, 0x0C, 0x01 -> entry_inc=1, entry_shift=0, disp_on=1, cursor_on=0, busy high 32 cycles, rd_char=0x20 at all indices.
- 0xC0 then data 'A'(0x41),'B' -> ac=0x42, rd_char at idx 16=0x41, idx 17=0x42.
- ac=0x27 with data write -> ac=0x40, nothing stored; entry 0x04, ac=0x40, data -> ac=0x27.
- Strobe during clear sweep -> err=1, dropped, next two nibbles still form one byte.
- With LCD_RX_READ_EN, rw=1 rs=0 read while busy, ac=0 -> rd_nib=0x8 then 0x0, rd_oe pulses per strobe.

Source files
------------

// File: rtl/lcd_nibble_rx.sv
// Loopback responder for the 4-bit character-LCD write bus: syncs the bus, runs the
// 8->4 bit init sequence, decodes instructions and mirrors a 32-char DDRAM. Optional read-back via LCD_RX_READ_EN.
module lcd_nibble_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sf_e,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_nib,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_rs,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       err,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic [3:0] rd_nib,
    output logic       rd_oe
);

    typedef enum logic [1:0] {
        M_INIT8 = 2'd0,
        M_HI    = 2'd1,
        M_LO    = 2'd2
    } mode_t;

    logic [7:0] bus_in;
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;
    logic       e_prev_q;
    logic       sf_s;
    logic       e_s;
    logic       fall_d;
    logic       strb_q;
    logic       smp_rs_q;
    logic       smp_rw_q;
    logic [3:0] smp_nib_q;

    mode_t      mode_q;
    logic [3:0] hi_q;
    logic       bv_q;
    logic [7:0] bd_q;
    logic       brs_q;
    logic       busy_q;
    logic       clr_pend_q;
    logic [4:0] clr_cnt_q;
    logic [6:0] ac_q;
    logic       disp_q;
    logic       cur_q;
    logic       blk_q;
    logic       inc_q;
    logic       shf_q;
    logic       err_q;
    logic [7:0] rd_char_q;

    logic [7:0] byte_d;
    logic [6:0] ac_step_d;
    logic       sweeping;
    logic       ac_ok;
    logic [4:0] ac_idx;
    logic       mem_we;
    logic [4:0] mem_waddr;
    logic [7:0] mem_wdata;

    logic [7:0] ddram_q [32];

    // Whole bus goes through the same two flops so rs/rw/nib stay aligned with e.
    assign bus_in = {sf_e, lcd_e, lcd_rs, lcd_rw, lcd_nib};
    assign sf_s   = sync2_q[7];
    assign e_s    = sync2_q[6];
    assign fall_d = sf_s & e_prev_q & ~e_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            e_prev_q  <= 1'b0;
            strb_q    <= 1'b0;
            smp_rs_q  <= 1'b0;
            smp_rw_q  <= 1'b0;
            smp_nib_q <= 4'h0;
        end else begin
            sync1_q   <= bus_in;
            sync2_q   <= sync1_q;
            e_prev_q  <= e_s;
            strb_q    <= fall_d;
            smp_rs_q  <= sync2_q[5];
            smp_rw_q  <= sync2_q[4];
            smp_nib_q <= sync2_q[3:0];
        end
    end

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)      r = 7'h40;
            else if (a == 7'h67) r = 7'h00;
            else                 r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    assign byte_d    = {hi_q, smp_nib_q};
    assign ac_step_d = ac_step(ac_q, inc_q);
    assign sweeping  = busy_q | clr_pend_q;

    // Only line 0 (0x00-0x0F) and line 1 (0x40-0x4F) windows are visible.
    always_comb begin
        ac_ok  = 1'b0;
        ac_idx = 5'd0;
        if (ac_q[6:4] == 3'b000) begin
            ac_ok  = 1'b1;
            ac_idx = {1'b0, ac_q[3:0]};
        end else if (ac_q[6:4] == 3'b100) begin
            ac_ok  = 1'b1;
            ac_idx = {1'b1, ac_q[3:0]};
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ac_idx;
        mem_wdata = byte_d;
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = 8'h20;
        end else if (strb_q && !smp_rw_q && !clr_pend_q && mode_q == M_LO
                     && smp_rs_q && ac_ok) begin
            mem_we = 1'b1;
        end
    end

`ifdef LCD_RX_READ_EN
    logic       rise_q;
    logic [3:0] rd_nib_q;
    logic       rd_oe_q;
    logic [7:0] rb_char_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q    <= 1'b0;
            rb_char_q <= 8'h00;
        end else begin
            rise_q    <= sf_s & ~e_prev_q & e_s;
            rb_char_q <= ac_ok ? ddram_q[ac_idx] : 8'h20;
        end
    end

    assign rd_nib = rd_nib_q;
    assign rd_oe  = rd_oe_q;
`else
    assign rd_nib = 4'h0;
    assign rd_oe  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= M_INIT8;
            hi_q       <= 4'h0;
            bv_q       <= 1'b0;
            bd_q       <= 8'h00;
            brs_q      <= 1'b0;
            busy_q     <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_cnt_q  <= 5'd0;
            ac_q       <= 7'h00;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blk_q      <= 1'b0;
            inc_q      <= 1'b1;
            shf_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef LCD_RX_READ_EN
            rd_nib_q   <= 4'h0;
            rd_oe_q    <= 1'b0;
`endif
        end else begin
            bv_q <= 1'b0;

            if (clr_pend_q) begin
                clr_pend_q <= 1'b0;
                busy_q     <= 1'b1;
                clr_cnt_q  <= 5'd0;
            end else if (busy_q) begin
                clr_cnt_q <= clr_cnt_q + 5'd1;
                if (clr_cnt_q == 5'd31) busy_q <= 1'b0;
            end

`ifdef LCD_RX_READ_EN
            if (rise_q && smp_rw_q) begin
                rd_oe_q <= 1'b1;
                if (smp_rs_q)
                    rd_nib_q <= (mode_q == M_LO) ? rb_char_q[3:0] : rb_char_q[7:4];
                else
                    rd_nib_q <= (mode_q == M_LO) ? ac_q[3:0] : {busy_q, ac_q[6:4]};
            end
`endif

            if (strb_q) begin
                if (smp_rw_q) begin
`ifdef LCD_RX_READ_EN
                    // Reads share the nibble phase with writes and are allowed during the sweep.
                    rd_oe_q <= 1'b0;
                    if (mode_q == M_HI) begin
                        mode_q <= M_LO;
                    end else if (mode_q == M_LO) begin
                        mode_q <= M_HI;
                        if (smp_rs_q) ac_q <= ac_step_d;
                    end
`endif
                end else if (sweeping) begin
                    err_q <= 1'b1;
                end else begin
                    case (mode_q)
                        M_INIT8: begin
                            if (smp_nib_q == 4'h2 && !smp_rs_q) mode_q <= M_HI;
                            else if (smp_nib_q != 4'h3)         err_q  <= 1'b1;
                        end
                        M_HI: begin
                            hi_q   <= smp_nib_q;
                            mode_q <= M_LO;
                        end
                        M_LO: begin
                            mode_q <= M_HI;
                            bv_q   <= 1'b1;
                            bd_q   <= byte_d;
                            brs_q  <= smp_rs_q;
                            if (smp_rs_q) begin
                                ac_q <= ac_step_d;
                            end else if (byte_d[7]) begin
                                ac_q <= byte_d[6:0];
                            end else if (byte_d[6:4] != 3'b000) begin
                                // function set / shift / CGRAM: no modelled state
                            end else if (byte_d[3]) begin
                                disp_q <= byte_d[2];
                                cur_q  <= byte_d[1];
                                blk_q  <= byte_d[0];
                            end else if (byte_d[2]) begin
                                inc_q <= byte_d[1];
                                shf_q <= byte_d[0];
                            end else if (byte_d[1]) begin
                                ac_q <= 7'h00;
                            end else if (byte_d[0]) begin
                                clr_pend_q <= 1'b1;
                                ac_q       <= 7'h00;
                                inc_q      <= 1'b1;
                            end
                        end
                        default: mode_q <= M_INIT8;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) ddram_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_char_q <= 8'h00;
        else        rd_char_q <= ddram_q[rd_idx];
    end

    assign byte_valid  = bv_q;
    assign byte_data   = bd_q;
    assign byte_rs     = brs_q;
    assign busy        = busy_q;
    assign ac          = ac_q;
    assign disp_on     = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blk_q;
    assign entry_inc   = inc_q;
    assign entry_shift = shf_q;
    assign err         = err_q;
    assign rd_char     = rd_char_q;

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Directed bench for lcd_nibble_rx: init sequence, decode, DDRAM mapping, ac wrap, clear sweep, error, read-back.
module tb_lcd_nibble_rx;

    logic       clk;
    logic       rst_n;
    logic       sf_e;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_nib;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       busy;
    logic [6:0] ac;
    logic       disp_on, cursor_on, blink_on, entry_inc, entry_shift, err;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;
    logic [3:0] rd_nib;
    logic       rd_oe;

    int n_cmp  = 0;
    int n_fail = 0;
    int bv_cnt = 0;

    lcd_nibble_rx dut (
        .clk(clk), .rst_n(rst_n), .sf_e(sf_e), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_nib(lcd_nib), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_rs(byte_rs), .busy(busy), .ac(ac),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .entry_inc(entry_inc), .entry_shift(entry_shift), .err(err),
        .rd_idx(rd_idx), .rd_char(rd_char), .rd_nib(rd_nib), .rd_oe(rd_oe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) if (rst_n && byte_valid) bv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One e pulse: 5 cycles high, 6 low. Read-back outputs sampled at the end of each half.
    task automatic strobe(input logic rs, input logic rw, input logic [3:0] nib,
                          output logic [3:0] hi_nib, output logic hi_oe, output logic lo_oe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_nib = nib; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        hi_nib = rd_nib; hi_oe = rd_oe;
        lcd_e = 1'b0;
        repeat (6) @(negedge clk);
        lo_oe = rd_oe;
        lcd_rw = 1'b0;
        $display("strobe rs=%0d rw=%0d nib=%0h ac=%0h err=%0d", rs, rw, nib, ac, err);
    endtask

    task automatic wnib(input logic rs, input logic [3:0] nib);
        logic [3:0] a; logic b, c;
        strobe(rs, 1'b0, nib, a, b, c);
    endtask

    task automatic wbyte(input logic rs, input logic [7:0] v);
        wnib(rs, v[7:4]);
        wnib(rs, v[3:0]);
    endtask

    task automatic rdchk(input string tag, input logic [4:0] idx, input logic [7:0] exp);
        rd_idx = idx;
        repeat (2) @(negedge clk);
        chk(tag, rd_char, exp);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    initial begin
        int bv_at, busy_at, busy_len, bv0, hits;
        logic [3:0] n1, n2;
        logic o1h, o1l, o2h, o2l;

        rst_n = 1'b0; sf_e = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_nib = 4'h0; rd_idx = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_bv", byte_valid, 0);
        chk("rst_bdata", byte_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ac", ac, 0);
        chk("rst_disp", {disp_on, cursor_on, blink_on}, 0);
        chk("rst_inc", entry_inc, 1);
        chk("rst_shift", entry_shift, 0);
        chk("rst_err", err, 0);
        chk("rst_rd", {rd_oe, rd_nib}, 0);
        chk("rst_rdchar", rd_char, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        wnib(0, 4'h3); wnib(0, 4'h3); wnib(0, 4'h3); wnib(0, 4'h2);
        chk("init_bv", bv_cnt, 0);
        chk("init_err", err, 0);

        wbyte(0, 8'h28);
        chk("fs_bv", bv_cnt, 1);
        chk("fs_data", byte_data, 8'h28);
        chk("fs_rs", byte_rs, 0);
        wbyte(0, 8'h07);
        chk("em07", {entry_inc, entry_shift}, 2'b11);
        wbyte(0, 8'h06);
        chk("em06", {entry_inc, entry_shift}, 2'b10);
        wbyte(0, 8'h0B);
        chk("dc0B", {disp_on, cursor_on, blink_on}, 3'b011);
        wbyte(0, 8'h0C);
        chk("dc0C", {disp_on, cursor_on, blink_on}, 3'b100);
        wbyte(0, 8'h04);
        chk("em04", entry_inc, 0);
        wbyte(0, 8'h85);
        chk("ac85", ac, 7'h05);

        // Clear with cycle-accurate busy measurement.
        wnib(0, 4'h0);
        bv0 = bv_cnt;
        @(negedge clk);
        lcd_nib = 4'h1; lcd_e = 1'b1;
        repeat (5) @(negedge clk);
        lcd_e = 1'b0;
        bv_at = -1; busy_at = -1; busy_len = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (byte_valid) bv_at = cyc;
            if (busy) begin
                if (busy_at < 0) busy_at = cyc;
                busy_len++;
            end
        end
        $display("clear bv_at=%0d busy_at=%0d busy_len=%0d", bv_at, busy_at, busy_len);
        chk("clr_bv", bv_cnt - bv0, 1);
        chk("clr_rise", busy_at - bv_at, 1);
        chk("clr_len", busy_len, 32);
        chk("clr_ac", ac, 0);
        chk("clr_inc", entry_inc, 1);
        for (int i = 0; i < 32; i++) rdchk("clr_ram", 5'(i), 8'h20);

        wbyte(0, 8'hC0);
        chk("acC0", ac, 7'h40);
        wbyte(1, 8'h41);
        wbyte(1, 8'h42);
        chk("dataAB_ac", ac, 7'h42);
        chk("dataAB_rs", byte_rs, 1);
        chk("dataAB_d", byte_data, 8'h42);
        rdchk("ram16", 5'd16, 8'h41);
        rdchk("ram17", 5'd17, 8'h42);

        wbyte(0, 8'hA7);
        wbyte(1, 8'h5A);
        chk("wrap27", ac, 7'h40);
        hits = 0;
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i);
            repeat (2) @(negedge clk);
            if (rd_char == 8'h5A) hits++;
        end
        chk("nostore27", hits, 0);

        wbyte(0, 8'h8F);
        wbyte(1, 8'h43);
        chk("ac0F_step", ac, 7'h10);
        rdchk("ram15", 5'd15, 8'h43);

        wbyte(0, 8'h04);
        wbyte(0, 8'hC0);
        wbyte(1, 8'h44);
        chk("dec40", ac, 7'h27);
        rdchk("ram16b", 5'd16, 8'h44);
        wbyte(0, 8'h80);
        wbyte(1, 8'h45);
        chk("dec00", ac, 7'h67);
        rdchk("ram0", 5'd0, 8'h45);

        wbyte(0, 8'h06);
        wbyte(0, 8'hE7);
        wbyte(1, 8'h46);
        chk("inc67", ac, 7'h00);
        rdchk("ram0b", 5'd0, 8'h45);

        wbyte(0, 8'h85);
        wbyte(0, 8'h03);
        chk("home_ac", ac, 0);
        chk("home_busy", busy, 0);

        // Status read during a clear sweep.
        wbyte(0, 8'h01);
        strobe(0, 1, 4'h0, n1, o1h, o1l);
        strobe(0, 1, 4'h0, n2, o2h, o2l);
`ifdef LCD_RX_READ_EN
        chk("rd_hi_nib", n1, 4'h8);
        chk("rd_hi_oe", {o1h, o1l}, 2'b10);
        chk("rd_lo_nib", n2, 4'h0);
        chk("rd_lo_oe", {o2h, o2l}, 2'b10);
`else
        chk("rd_hi_off", {o1h, o1l, n1}, 0);
        chk("rd_lo_off", {o2h, o2l, n2}, 0);
`endif
        chk("rd_err", err, 0);
        wait_idle("rd_idle");

        // Write strobe during the sweep must be dropped without advancing the phase.
        wbyte(0, 8'h01);
        chk("err_busy", busy, 1);
        bv0 = bv_cnt;
        wnib(0, 4'hF);
        chk("err_set", err, 1);
        chk("err_nobv", bv_cnt - bv0, 0);
        wait_idle("err_idle");
        wbyte(0, 8'h0E);
        chk("err_byte", byte_data, 8'h0E);
        chk("err_dc", {disp_on, cursor_on, blink_on}, 3'b110);
        chk("err_sticky", err, 1);

        // Reset with a half byte pending.
        wnib(0, 4'h8);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_err", err, 0);
        chk("mrst_ac", ac, 0);
        chk("mrst_disp", disp_on, 0);
        chk("mrst_inc", entry_inc, 1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wnib(0, 4'h4);
        chk("mrst_init8", err, 1);
        wnib(0, 4'h2);
        wbyte(0, 8'h84);
        chk("mrst_ac84", ac, 7'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
